// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
// Shares the single GPR write port between the execute unit (EXE) and the
// load/store unit (LSU). Round-robin arbitration on ties, valid/ready
// handshakes, one registered write per cycle, writes to x0 are dropped.
//
// Parameters:
//   XLEN   data width of a GPR write
//   AW     register index width
//   CNT_W  stall counter width (only with WB_ARB_PERF_EN)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exe_valid/exe_rd/exe_data     EXE writeback request
//   exe_ready                     EXE request accepted this cycle (comb)
//   lsu_valid/lsu_rd/lsu_data     LSU writeback request
//   lsu_ready                     LSU request accepted this cycle (comb)
//   wb_hold                       freeze writeback
//   rf_wen/rf_waddr/rf_wdata      registered register file write port
//   exe_stall_cnt/lsu_stall_cnt   saturating stall counters (WB_ARB_PERF_EN)
//
// Optional feature macro: WB_ARB_PERF_EN adds the stall counters.
// -----------------------------------------------------------------------------
module gpr_wb_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    input  logic [AW-1:0]    exe_rd,
    input  logic [XLEN-1:0]  exe_data,
    output logic             exe_ready,
    input  logic             lsu_valid,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             lsu_ready,
    input  logic             wb_hold,
`ifdef WB_ARB_PERF_EN
    output logic [CNT_W-1:0] exe_stall_cnt,
    output logic [CNT_W-1:0] lsu_stall_cnt,
`endif
    output logic             rf_wen,
    output logic [AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]  rf_wdata
);

    localparam logic GRANT_EXE = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    logic            last_grant_q, last_grant_d;
    logic            rf_wen_q,     rf_wen_d;
    logic [AW-1:0]   rf_waddr_q,   rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q,   rf_wdata_d;

    logic exe_xfer;
    logic lsu_xfer;

    // Grant: nothing during reset/hold; on a tie the requester not last granted wins
    always_comb begin
        exe_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst && !wb_hold) begin
            if (exe_valid && lsu_valid) begin
                if (last_grant_q == GRANT_EXE) begin
                    lsu_ready = 1'b1;
                end else begin
                    exe_ready = 1'b1;
                end
            end else begin
                exe_ready = exe_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    assign exe_xfer = exe_valid && exe_ready;
    assign lsu_xfer = lsu_valid && lsu_ready;

    // Next-state for the write port and arbitration history
    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (exe_xfer) begin
            last_grant_d = GRANT_EXE;
            if (exe_rd != '0) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = exe_rd;
                rf_wdata_d = exe_data;
            end
        end else if (lsu_xfer) begin
            last_grant_d = GRANT_LSU;
            if (lsu_rd != '0) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = lsu_rd;
                rf_wdata_d = lsu_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_EXE;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0] exe_stall_q, exe_stall_d;
    logic [CNT_W-1:0] lsu_stall_q, lsu_stall_d;

    // Saturating stall counters; hold cycles count as stalls
    always_comb begin
        exe_stall_d = exe_stall_q;
        lsu_stall_d = lsu_stall_q;
        if (exe_valid && !exe_ready && (exe_stall_q != '1)) begin
            exe_stall_d = exe_stall_q + CNT_W'(1);
        end
        if (lsu_valid && !lsu_ready && (lsu_stall_q != '1)) begin
            lsu_stall_d = lsu_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_stall_q <= '0;
            lsu_stall_q <= '0;
        end else begin
            exe_stall_q <= exe_stall_d;
            lsu_stall_q <= lsu_stall_d;
        end
    end

    assign exe_stall_cnt = exe_stall_q;
    assign lsu_stall_cnt = lsu_stall_q;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            exe_valid, lsu_valid, wb_hold;
    logic [AW-1:0]   exe_rd, lsu_rd;
    logic [XLEN-1:0] exe_data, lsu_data;
    logic            exe_ready, lsu_ready;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0] exe_stall_cnt, lsu_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .exe_valid (exe_valid),
        .exe_rd    (exe_rd),
        .exe_data  (exe_data),
        .exe_ready (exe_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .wb_hold   (wb_hold),
`ifdef WB_ARB_PERF_EN
        .exe_stall_cnt (exe_stall_cnt),
        .lsu_stall_cnt (lsu_stall_cnt),
`endif
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; exe_valid = 1'b0; lsu_valid = 1'b0; wb_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_hold = 1'b0;
        exe_valid = 1'b1; exe_rd = 5'd3; exe_data = 64'h3;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (exe_ready !== 1'b0) begin n_fail++; $display("FAIL t1_exe_ready got %b exp 0", exe_ready); end
            n_checks++;
            if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL t1_lsu_ready got %b exp 0", lsu_ready); end
        end
        rst = 1'b0; exe_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t1_rf_wen got %b exp 0", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL t1_rf_waddr got %0d exp 0", rf_waddr); end
        n_checks++;
        if (rf_wdata !== 64'h0) begin n_fail++; $display("FAIL t1_rf_wdata got %h exp 0", rf_wdata); end
    endtask

    task automatic test_single_exe();
        @(negedge clk);
        exe_valid = 1'b1; exe_rd = 5'd17; exe_data = 64'h1234;
        #1;
        n_checks++;
        if (exe_ready !== 1'b1) begin n_fail++; $display("FAIL t2_exe_ready got %b exp 1", exe_ready); end
        n_checks++;
        if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL t2_lsu_ready got %b exp 0", lsu_ready); end
        @(negedge clk);
        exe_valid = 1'b0;
        n_checks++;
        if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL t2_rf_wen got %b exp 1", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd17) begin n_fail++; $display("FAIL t2_rf_waddr got %0d exp 17", rf_waddr); end
        n_checks++;
        if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL t2_rf_wdata got %h exp 1234", rf_wdata); end
    endtask

    task automatic test_tie();
        logic            exp_lsu;
        logic [AW-1:0]   exp_addr;
        logic [XLEN-1:0] exp_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                // previous cycle's winner: LSU on even k-1, EXE on odd k-1
                exp_addr = ((k - 1) % 2 == 0) ? 5'd18 : 5'd19;
                exp_data = ((k - 1) % 2 == 0) ? 64'hAAAA : 64'hBBBB;
                n_checks++;
                if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL t3_rf_wen[%0d] got %b exp 1", k, rf_wen); end
                n_checks++;
                if (rf_waddr !== exp_addr) begin n_fail++; $display("FAIL t3_rf_waddr[%0d] got %0d exp %0d", k, rf_waddr, exp_addr); end
                n_checks++;
                if (rf_wdata !== exp_data) begin n_fail++; $display("FAIL t3_rf_wdata[%0d] got %h exp %h", k, rf_wdata, exp_data); end
            end
            if (k == 4) begin
                exe_valid = 1'b0; lsu_valid = 1'b0;
            end else begin
                exe_valid = 1'b1; exe_rd = 5'd19; exe_data = 64'hBBBB;
                lsu_valid = 1'b1; lsu_rd = 5'd18; lsu_data = 64'hAAAA;
                #1;
                exp_lsu = (k % 2 == 0);
                n_checks++;
                if (lsu_ready !== exp_lsu) begin n_fail++; $display("FAIL t3_lsu_ready[%0d] got %b exp %b", k, lsu_ready, exp_lsu); end
                n_checks++;
                if (exe_ready !== !exp_lsu) begin n_fail++; $display("FAIL t3_exe_ready[%0d] got %b exp %b", k, exe_ready, !exp_lsu); end
            end
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hDEAD;
        #1;
        n_checks++;
        if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL t4_lsu_ready got %b exp 1", lsu_ready); end
        @(negedge clk);
        lsu_valid = 1'b0;
        n_checks++;
        if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t4_rf_wen got %b exp 0", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd19) begin n_fail++; $display("FAIL t4_rf_waddr got %0d exp 19", rf_waddr); end
        n_checks++;
        if (rf_wdata !== 64'hBBBB) begin n_fail++; $display("FAIL t4_rf_wdata got %h exp bbbb", rf_wdata); end
    endtask

    task automatic test_hold();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t5_rf_wen_hold[%0d] got %b exp 0", i, rf_wen); end
            end
            wb_hold = 1'b1; exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 64'h55;
            #1;
            n_checks++;
            if (exe_ready !== 1'b0) begin n_fail++; $display("FAIL t5_exe_ready_hold[%0d] got %b exp 0", i, exe_ready); end
        end
        @(negedge clk);
        n_checks++;
        if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t5_rf_wen_hold[3] got %b exp 0", rf_wen); end
`ifdef WB_ARB_PERF_EN
        n_checks++;
        if (exe_stall_cnt !== 4'd3) begin n_fail++; $display("FAIL t5_exe_stall_cnt got %0d exp 3", exe_stall_cnt); end
`endif
        wb_hold = 1'b0;
        #1;
        n_checks++;
        if (exe_ready !== 1'b1) begin n_fail++; $display("FAIL t5_exe_ready_release got %b exp 1", exe_ready); end
        @(negedge clk);
        exe_valid = 1'b0;
        n_checks++;
        if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL t5_rf_wen_release got %b exp 1", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL t5_rf_waddr got %0d exp 5", rf_waddr); end
        n_checks++;
        if (rf_wdata !== 64'h55) begin n_fail++; $display("FAIL t5_rf_wdata got %h exp 55", rf_wdata); end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wb_hold = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
            #1;
            n_checks++;
            if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL t6_lsu_ready[%0d] got %b exp 0", i, lsu_ready); end
        end
        @(negedge clk);
`ifdef WB_ARB_PERF_EN
        n_checks++;
        if (lsu_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL t6_lsu_stall_cnt got %0d exp 15", lsu_stall_cnt); end
        n_checks++;
        if (exe_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL t6_exe_stall_cnt got %0d exp 0", exe_stall_cnt); end
`endif
        n_checks++;
        if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t6_rf_wen got %b exp 0", rf_wen); end
        wb_hold = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        exe_valid = 1'b1; exe_rd = 5'd9; exe_data = 64'h99; rst = 1'b1;
        #1;
        n_checks++;
        if (exe_ready !== 1'b0) begin n_fail++; $display("FAIL t7_exe_ready_rst got %b exp 0", exe_ready); end
        @(negedge clk);
        rst = 1'b0; exe_valid = 1'b0;
        n_checks++;
        if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL t7_rf_wen got %b exp 0", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL t7_rf_waddr got %0d exp 0", rf_waddr); end
    endtask

    initial begin
        test_reset();
        test_single_exe();
        test_tie();
        test_x0_write();
        test_hold();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
